// File: rtl/fp_pkg.sv
// Shared constants for the pipelined floating-point adder.
// Field geometry, special encodings and flag bit positions.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int GRS_W     = 3;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int fp_width(int e, int m);
    return 1 + e + m;
  endfunction

  function automatic int fp_bias(int e);
    return (1 << (e - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_inf(int e, int m);
    return ((64'd1 << e) - 64'd1) << m;
  endfunction

  function automatic logic [63:0] fp_qnan(int e, int m);
    return fp_inf(e, m) | (64'd1 << (m - 1));
  endfunction

endpackage

// File: rtl/fp_add_pipe_lzc.sv
// Leading-zero counter; an all-zero input returns WIDTH.
// Purely combinational, scans so the highest set bit wins.
module fp_lzc #(
  parameter  int WIDTH = 27,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o
);

  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_i[i]) cnt_o = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage IEEE-style adder: unpack/swap, align/add, normalise/round.
// Valid/ready pipeline with bubble collapsing; denormals flush to zero.
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter  int EXP_W = EXP_W_DEF,
  parameter  int MAN_W = MAN_W_DEF,
  localparam int N     = fp_width(EXP_W, MAN_W)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic [3:0]   flags
);

  localparam int SW  = MAN_W + 1;
  localparam int AW  = SW + GRS_W;
  localparam int RW  = AW + 1;
  localparam int XW  = EXP_W + 2;
  localparam int MW  = EXP_W + MAN_W;
  localparam int RSW = SW + 1;
  localparam int LW  = $clog2(AW + 1);

  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [N-1:0] QNAN = N'(fp_qnan(EXP_W, MAN_W));
  localparam logic [N-1:0] INF  = N'(fp_inf(EXP_W, MAN_W));

  logic v1_q, v2_q, v3_q;
  logic en1, en2, en3;

  assign en3      = !v3_q || out_ready;
  assign en2      = !v2_q || en3;
  assign en1      = !v1_q || en2;
  assign in_ready = en1;

  // S1: unpack, flush, magnitude compare and swap
  logic             sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic [MW-1:0]    ma, mb;
  logic [MW-1:0]    mgl_d, mgs_d, mgl_q, mgs_q;
  logic             sgl_d, sgs_d, nan1_d, inf1_d, infs1_d;
  logic             sgl_q, sgs_q, nan1_q, inf1_q, infs1_q;

  always_comb begin
    sa      = a[N-1];
    sb      = b[N-1] ^ sub;
    ea      = a[N-2 -: EXP_W];
    eb      = b[N-2 -: EXP_W];
    fa      = a[MAN_W-1:0];
    fb      = b[MAN_W-1:0];
    a_nan   = (ea == EMAX) && (fa != '0);
    b_nan   = (eb == EMAX) && (fb != '0);
    a_inf   = (ea == EMAX) && (fa == '0);
    b_inf   = (eb == EMAX) && (fb == '0);
    ma      = (ea == '0) ? '0 : {ea, fa};
    mb      = (eb == '0) ? '0 : {eb, fb};
    swap    = mb > ma;
    sgl_d   = swap ? sb : sa;
    sgs_d   = swap ? sa : sb;
    mgl_d   = swap ? mb : ma;
    mgs_d   = swap ? ma : mb;
    nan1_d  = a_nan || b_nan || (a_inf && b_inf && (sa != sb));
    inf1_d  = a_inf || b_inf;
    infs1_d = a_inf ? sa : sb;
  end

  // S2: align smaller significand, then add or subtract
  logic [EXP_W-1:0] exl, exs, diff;
  logic [SW-1:0]    sigl, sigs;
  logic [AW-1:0]    ext, aln;
  logic [2*AW-1:0]  wide;
  logic [RW-1:0]    big, sml, sum2_d, sum2_q;
  logic             eff_sub;
  logic [EXP_W-1:0] exp2_q;
  logic             sgn2_q, sub2_q, nan2_q, inf2_q, infs2_q;

  always_comb begin
    exl     = mgl_q[MW-1 -: EXP_W];
    exs     = mgs_q[MW-1 -: EXP_W];
    sigl    = {|exl, mgl_q[MAN_W-1:0]};
    sigs    = {|exs, mgs_q[MAN_W-1:0]};
    diff    = exl - exs;
    ext     = {sigs, {GRS_W{1'b0}}};
    wide    = {ext, {AW{1'b0}}} >> diff;
    if (32'(diff) >= AW - 1) begin
      aln = {{(AW-1){1'b0}}, |sigs};
    end else begin
      aln = {wide[2*AW-1:AW+1], wide[AW] | (|wide[AW-1:0])};
    end
    eff_sub = sgl_q ^ sgs_q;
    big     = {1'b0, sigl, {GRS_W{1'b0}}};
    sml     = {1'b0, aln};
    sum2_d  = eff_sub ? big - sml : big + sml;
  end

  // S3: normalise, round to nearest even, pack
  logic [LW-1:0]    lz;
  logic [AW-1:0]    nrm;
  logic [XW-1:0]    ebase, exn, exr;
  logic [RSW-1:0]   rsum;
  logic [MAN_W-1:0] frac;
  logic             inx, rup;
  logic [N-1:0]     c_d, c_q;
  logic [3:0]       flags_d, flags_q;

  fp_lzc #(.WIDTH(AW)) u_lzc (
    .in_i  (sum2_q[AW-1:0]),
    .cnt_o (lz)
  );

  always_comb begin
    c_d     = '0;
    flags_d = '0;
    ebase   = {2'b00, exp2_q};
    if (sum2_q[AW]) begin
      nrm = {sum2_q[AW:2], sum2_q[1] | sum2_q[0]};
      exn = ebase + XW'(1);
    end else begin
      nrm = sum2_q[AW-1:0] << lz;
      exn = ebase - XW'(lz);
    end
    inx  = |nrm[GRS_W-1:0];
    rup  = nrm[2] && (nrm[1] || nrm[0] || nrm[3]);
    rsum = {1'b0, nrm[AW-1:GRS_W]} + RSW'(rup);
    if (rsum[SW]) begin
      exr  = exn + XW'(1);
      frac = rsum[MAN_W:1];
    end else begin
      exr  = exn;
      frac = rsum[MAN_W-1:0];
    end
    if (nan2_q) begin
      c_d              = QNAN;
      flags_d[FLG_INV] = 1'b1;
    end else if (inf2_q) begin
      c_d = {infs2_q, INF[N-2:0]};
    end else if (sum2_q == '0) begin
      c_d = {!sub2_q && sgn2_q, {(N-1){1'b0}}};
    end else if (!exr[XW-1] && exr >= {2'b00, EMAX}) begin
      c_d              = {sgn2_q, INF[N-2:0]};
      flags_d[FLG_OVF] = 1'b1;
      flags_d[FLG_INX] = 1'b1;
    end else if (exr[XW-1] || exr == '0) begin
      c_d              = {sgn2_q, {(N-1){1'b0}}};
      flags_d[FLG_UNF] = 1'b1;
      flags_d[FLG_INX] = 1'b1;
    end else begin
      c_d              = {sgn2_q, exr[EXP_W-1:0], frac};
      flags_d[FLG_INX] = inx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      c_q     <= '0;
      flags_q <= '0;
    end else begin
      if (en1) v1_q <= in_valid;
      if (en2) v2_q <= v1_q;
      if (en3) v3_q <= v2_q;
      if (en3 && v2_q) begin
        c_q     <= c_d;
        flags_q <= flags_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en1 && in_valid) begin
      sgl_q   <= sgl_d;
      sgs_q   <= sgs_d;
      mgl_q   <= mgl_d;
      mgs_q   <= mgs_d;
      nan1_q  <= nan1_d;
      inf1_q  <= inf1_d;
      infs1_q <= infs1_d;
    end
    if (en2 && v1_q) begin
      sum2_q  <= sum2_d;
      exp2_q  <= exl;
      sgn2_q  <= sgl_q;
      sub2_q  <= eff_sub;
      nan2_q  <= nan1_q;
      inf2_q  <= inf1_q;
      infs2_q <= infs1_q;
    end
  end

  assign out_valid = v3_q;
  assign c         = c_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: directed vectors, stall stream,
// mid-flight reset. Monitor pops expectations on each transfer.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b, c;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  flags;

  typedef struct {
    logic [31:0] c;
    logic [3:0]  f;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  bit   pat_en  = 1'b0;
  bit   or_hold = 1'b1;
  bit [3:0] pat = 4'b1001;

  always #5 clk = ~clk;

  fp_add_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .flags     (flags)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // out_ready driver: fixed level, or the 1,0,0,1 stall pattern
  initial begin
    int k;
    k = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pat_en) begin
        out_ready = pat[k % 4];
        k++;
      end else begin
        out_ready = or_hold;
      end
    end
  end

  // monitor: compare on transfer, check hold during stalls
  initial begin
    bit          held;
    logic [31:0] hc;
    logic [3:0]  hf;
    exp_t        e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_c", c, hc);
          chk("stall_flags", flags, hf);
        end
        held = 1'b0;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL spurious_result: c=%h with empty scoreboard", c);
          end else begin
            e = q.pop_front();
            chk({e.nm, "_c"}, c, e.c);
            chk({e.nm, "_flags"}, flags, e.f);
          end
        end else if (out_valid) begin
          held = 1'b1;
          hc   = c;
          hf   = flags;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic isub, input logic [31:0] ec,
                       input logic [3:0] ef, input string nm);
    exp_t e;
    bit   ok;
    ok       = 1'b0;
    a        = ia;
    b        = ib;
    sub      = isub;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    @(posedge clk);
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout %s: in_ready 0 required 1", nm);
    end else begin
      e.c  = ec;
      e.f  = ef;
      e.nm = nm;
      q.push_back(e);
    end
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain_%s: %0d pending required 0", nm, q.size());
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] va[16], vb[16], vc[16];
  logic        vs[16];
  logic [3:0]  vf[16];
  string       vn[16];
  logic [31:0] fint[10];

  initial begin
    va[0]=32'h40400000; vb[0]=32'h3F800000; vs[0]=1; vc[0]=32'h40000000; vf[0]=4'h0; vn[0]="sub_3_1";
    va[1]=32'h3FC00000; vb[1]=32'hBFC00000; vs[1]=0; vc[1]=32'h00000000; vf[1]=4'h0; vn[1]="cancel";
    va[2]=32'h7F800000; vb[2]=32'hFF800000; vs[2]=0; vc[2]=32'h7FC00000; vf[2]=4'h8; vn[2]="inf_m_inf";
    va[3]=32'h7F7FFFFF; vb[3]=32'h7F7FFFFF; vs[3]=0; vc[3]=32'h7F800000; vf[3]=4'h5; vn[3]="overflow";
    va[4]=32'h3F800000; vb[4]=32'h33800000; vs[4]=0; vc[4]=32'h3F800000; vf[4]=4'h1; vn[4]="tie_even";
    va[5]=32'h3F800000; vb[5]=32'h33800001; vs[5]=0; vc[5]=32'h3F800001; vf[5]=4'h1; vn[5]="round_up";
    va[6]=32'h00000000; vb[6]=32'h80000000; vs[6]=0; vc[6]=32'h00000000; vf[6]=4'h0; vn[6]="pz_nz";
    va[7]=32'h80000000; vb[7]=32'h80000000; vs[7]=0; vc[7]=32'h80000000; vf[7]=4'h0; vn[7]="nz_nz";
    va[8]=32'h7F800000; vb[8]=32'h3F800000; vs[8]=0; vc[8]=32'h7F800000; vf[8]=4'h0; vn[8]="inf_p_one";
    va[9]=32'h3F800000; vb[9]=32'h7F800000; vs[9]=1; vc[9]=32'hFF800000; vf[9]=4'h0; vn[9]="one_m_inf";
    va[10]=32'h7FC00001; vb[10]=32'h3F800000; vs[10]=0; vc[10]=32'h7FC00000; vf[10]=4'h8; vn[10]="nan_in";
    va[11]=32'h00800001; vb[11]=32'h00800000; vs[11]=1; vc[11]=32'h00000000; vf[11]=4'h3; vn[11]="underflow";
    va[12]=32'h3F800000; vb[12]=32'h40000000; vs[12]=1; vc[12]=32'hBF800000; vf[12]=4'h0; vn[12]="neg_res";
    va[13]=32'h4B7FFFFF; vb[13]=32'h3F000000; vs[13]=0; vc[13]=32'h4B800000; vf[13]=4'h1; vn[13]="rnd_carry";
    va[14]=32'h00400000; vb[14]=32'h3F800000; vs[14]=0; vc[14]=32'h3F800000; vf[14]=4'h0; vn[14]="den_flush";
    va[15]=32'h3F800000; vb[15]=32'h3F000000; vs[15]=0; vc[15]=32'h3FC00000; vf[15]=4'h0; vn[15]="one_half";
    fint[0]=32'h00000000; fint[1]=32'h3F800000; fint[2]=32'h40000000;
    fint[3]=32'h40400000; fint[4]=32'h40800000; fint[5]=32'h40A00000;
    fint[6]=32'h40C00000; fint[7]=32'h40E00000; fint[8]=32'h41000000;
    fint[9]=32'h41100000;
  end

  initial begin
    int seen;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    sub      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_c", c, 0);
    chk("rst_flags", flags, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // latency: out_valid appears in the third cycle after acceptance
    issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0, "one_p_one");
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle2", out_valid, 0);
    @(negedge clk);
    chk("lat_cycle3", out_valid, 1);
    drain("latency");

    for (int i = 0; i < 16; i++) begin
      issue(va[i], vb[i], vs[i], vc[i], vf[i], vn[i]);
    end
    in_valid = 1'b0;
    drain("directed");

    pat_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(fint[i+1], fint[1], 1'b0, fint[i+2], 4'h0,
            $sformatf("stream%0d", i));
    end
    in_valid = 1'b0;
    drain("stream");
    pat_en = 1'b0;

    // mid-flight reset with a full, stalled pipeline
    or_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    issue(fint[1], fint[1], 1'b0, fint[2], 4'h0, "flush0");
    issue(fint[2], fint[1], 1'b0, fint[3], 4'h0, "flush1");
    issue(fint[3], fint[1], 1'b0, fint[4], 4'h0, "flush2");
    rst = 1'b1;
    a   = fint[5];
    b   = fint[1];
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_c", c, 0);
    chk("midrst_flags", flags, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    or_hold  = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale_after_rst", seen, 0);
    @(posedge clk);
    #1;

    issue(32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 4'h0, "post_rst");
    in_valid = 1'b0;
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
